// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter_pkg
// Purpose  : Shared definitions for the CDB arbiter and its consumers: unit
//            index constants, the broadcast record and the round-robin index
//            helper.
// Revision : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

  // Submitting execution units, in their fixed index order.
  localparam int UNIT_INT  = 0;
  localparam int UNIT_MULT = 1;
  localparam int UNIT_DIV  = 2;
  localparam int UNIT_MEM  = 3;

  localparam int CDB_TAG_W  = 6;
  localparam int CDB_DATA_W = 32;
  localparam int CDB_SRC_W  = 2;

  // One broadcast as seen by reservation stations, ROB and register status.
  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_SRC_W-1:0]  src;
  } cdb_bcast_t;

  // Index reached after stepping 'off' places from 'base' in a ring of 'n'.
  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_slot_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cdb_slot_fifo
// Purpose  : Small per-unit result buffer (tag + data) with push, pop and a
//            synchronous flush. Full/empty derive from an occupancy counter.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_slot_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [TAG_W-1:0]  o_head_tag,
  output logic [DATA_W-1:0] o_head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TAG_W-1:0]  tag_mem_q  [DEPTH];
  logic [TAG_W-1:0]  tag_mem_d  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];

  logic push_en;
  logic pop_en;

  assign o_full      = (count_q == CNT_W'(DEPTH));
  assign o_empty     = (count_q == '0);
  assign o_head_tag  = tag_mem_q[rd_ptr_q];
  assign o_head_data = data_mem_q[rd_ptr_q];

  // A push into a full buffer or a pop from an empty one is ignored.
  assign push_en = i_push & ~o_full;
  assign pop_en  = i_pop & ~o_empty;

  // Next-state for pointers, occupancy and storage; flush wins over all.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tag_mem_d  = tag_mem_q;
    data_mem_d = data_mem_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        tag_mem_d[wr_ptr_q]  = i_tag;
        data_mem_d[wr_ptr_q] = i_data;
        // DEPTH is a power of two, so the pointer wraps naturally.
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_q[i]  <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tag_mem_q  <= tag_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Collects results from the int/mult/div/mem execution units into
//            per-unit buffers and broadcasts one result per cycle on the CDB
//            under round-robin arbitration.
// Options  : CDB_BYPASS_EN - an empty unit may compete with its incoming
//            result in the same cycle (1-cycle latency when it wins).
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_flush,
  input  logic [N_UNITS-1:0]          i_submit_valid,
  input  logic [N_UNITS*TAG_W-1:0]    i_submit_tag,
  input  logic [N_UNITS*DATA_W-1:0]   i_submit_data,
  output logic [N_UNITS-1:0]          o_submit_ready,
  output logic                        o_cdb_valid,
  output logic [TAG_W-1:0]            o_cdb_tag,
  output logic [DATA_W-1:0]           o_cdb_data,
  output logic [$clog2(N_UNITS)-1:0]  o_cdb_src
);

  localparam int SRC_W = $clog2(N_UNITS);

  logic [N_UNITS-1:0] full;
  logic [N_UNITS-1:0] empty;
  logic [N_UNITS-1:0] push;
  logic [N_UNITS-1:0] pop;
  logic [N_UNITS-1:0] req;
  logic [TAG_W-1:0]   sub_tag   [N_UNITS];
  logic [DATA_W-1:0]  sub_data  [N_UNITS];
  logic [TAG_W-1:0]   head_tag  [N_UNITS];
  logic [DATA_W-1:0]  head_data [N_UNITS];

  logic              win_found;
  logic [SRC_W-1:0]  win_idx;
  logic [SRC_W-1:0]  cand;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;

  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  assign o_submit_ready = ~full;

  generate
    for (genvar k = 0; k < N_UNITS; k++) begin : g_unit
      assign sub_tag[k]  = i_submit_tag[k*TAG_W +: TAG_W];
      assign sub_data[k] = i_submit_data[k*DATA_W +: DATA_W];
      assign pop[k]      = win_found & (win_idx == SRC_W'(k)) & ~empty[k];
`ifdef CDB_BYPASS_EN
      // A result that wins straight from the input never enters the buffer.
      assign push[k] = i_submit_valid[k] & ~full[k] & ~i_flush &
                       ~(win_found & (win_idx == SRC_W'(k)) & empty[k]);
`else
      assign push[k] = i_submit_valid[k] & ~full[k] & ~i_flush;
`endif

      cdb_slot_fifo #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
      ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_flush),
        .i_push      (push[k]),
        .i_tag       (sub_tag[k]),
        .i_data      (sub_data[k]),
        .i_pop       (pop[k]),
        .o_full      (full[k]),
        .o_empty     (empty[k]),
        .o_head_tag  (head_tag[k]),
        .o_head_data (head_data[k])
      );
    end
  endgenerate

  // Round-robin winner search starting at the pointer; nothing competes
  // during a flush so the broadcast valid drops on the flush edge.
  always_comb begin
    req       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (!i_flush) begin
`ifdef CDB_BYPASS_EN
      req = ~empty | i_submit_valid;
`else
      req = ~empty;
`endif
    end
    for (int i = 0; i < N_UNITS; i++) begin
      cand = SRC_W'(rr_index(32'(ptr_q), i, N_UNITS));
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Winner payload: buffer head, or the live input when bypassing.
  always_comb begin
    win_tag  = head_tag[win_idx];
    win_data = head_data[win_idx];
`ifdef CDB_BYPASS_EN
    if (empty[win_idx]) begin
      win_tag  = sub_tag[win_idx];
      win_data = sub_data[win_idx];
    end
`endif
  end

  // Next pointer and CDB register contents; payload holds when idle.
  always_comb begin
    ptr_d       = ptr_q;
    cdb_valid_d = win_found;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (win_found) begin
      ptr_d      = SRC_W'(rr_index(32'(win_idx), 1, N_UNITS));
      cdb_tag_d  = win_tag;
      cdb_data_d = win_data;
      cdb_src_d  = win_idx;
    end
  end

  // Pointer and broadcast registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign o_cdb_valid = cdb_valid_q;
  assign o_cdb_tag   = cdb_tag_q;
  assign o_cdb_data  = cdb_data_q;
  assign o_cdb_src   = cdb_src_q;

`ifndef SYNTHESIS
  // A unit must never strobe a completion into a full buffer.
  a_no_submit_when_full : assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
      ((i_submit_valid & ~o_submit_ready) == '0)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Self-checking bench for cdb_arbiter (default build, 2-cycle
//            latency): vector table plus reset, wrap, backpressure and flush
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  sub_valid;
  logic [23:0] sub_tag;
  logic [127:0] sub_data;
  logic [3:0]  ready;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(
    .N_UNITS (4),
    .TAG_W   (6),
    .DATA_W  (32),
    .DEPTH   (2)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flush        (flush),
    .i_submit_valid (sub_valid),
    .i_submit_tag   (sub_tag),
    .i_submit_data  (sub_data),
    .o_submit_ready (ready),
    .o_cdb_valid    (cdb_valid),
    .o_cdb_tag      (cdb_tag),
    .o_cdb_data     (cdb_data),
    .o_cdb_src      (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       valid;
    logic [3:0][5:0]  tag;
    logic [3:0][31:0] data;
    logic             flush;
    logic [3:0]       exp_ready;
    logic             exp_valid;
    logic [5:0]       exp_tag;
    logic [31:0]      exp_data;
    logic [1:0]       exp_src;
  } vec_t;

  vec_t vecs [17];

  // Present units get tag tbase+k and data dbase+k.
  function automatic vec_t mk(input logic [3:0] valid, input logic [5:0] tbase,
                              input logic [31:0] dbase, input logic [3:0] er,
                              input logic ev, input logic [5:0] et,
                              input logic [31:0] ed, input logic [1:0] es);
    vec_t v;
    v.valid = valid;
    v.flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v.tag[k]  = valid[k] ? tbase + 6'(k) : 6'd0;
      v.data[k] = valid[k] ? dbase + 32'(k) : 32'd0;
    end
    v.exp_ready = er;
    v.exp_valid = ev;
    v.exp_tag   = et;
    v.exp_data  = ed;
    v.exp_src   = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sub_valid = '0;
    sub_tag   = '0;
    sub_data  = '0;
    flush     = 1'b0;
  endtask

  task automatic drive_one(input int k, input logic [5:0] t, input logic [31:0] d);
    sub_valid[k]         = 1'b1;
    sub_tag[k*6 +: 6]    = t;
    sub_data[k*32 +: 32] = d;
  endtask

  logic [5:0] exp_q [4][$];
  int         seq [4];
  logic       ready1_fell;
  logic [5:0] ft;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(cdb_valid), 32'd0);
    chk("reset_tag",   32'(cdb_tag),   32'd0);
    chk("reset_data",  cdb_data,       32'd0);
    chk("reset_src",   32'(cdb_src),   32'd0);
    chk("reset_ready", 32'(ready),     32'hF);
    rst_n = 1'b1;
    tick();

    // Two back-to-back full batches, single submit, then pointer-wrap order.
    vecs[0]  = mk(4'hF, 6'h10, 32'h1000, 4'hF, 0, 6'h00, 32'h0,    2'd0);
    vecs[1]  = mk(4'hF, 6'h20, 32'h2000, 4'h1, 1, 6'h10, 32'h1000, 2'd0);
    vecs[2]  = mk(4'h0, 6'h00, 32'h0,    4'h3, 1, 6'h11, 32'h1001, 2'd1);
    vecs[3]  = mk(4'h0, 6'h00, 32'h0,    4'h7, 1, 6'h12, 32'h1002, 2'd2);
    vecs[4]  = mk(4'h0, 6'h00, 32'h0,    4'hF, 1, 6'h13, 32'h1003, 2'd3);
    vecs[5]  = mk(4'h0, 6'h00, 32'h0,    4'hF, 1, 6'h20, 32'h2000, 2'd0);
    vecs[6]  = mk(4'h0, 6'h00, 32'h0,    4'hF, 1, 6'h21, 32'h2001, 2'd1);
    vecs[7]  = mk(4'h0, 6'h00, 32'h0,    4'hF, 1, 6'h22, 32'h2002, 2'd2);
    vecs[8]  = mk(4'h0, 6'h00, 32'h0,    4'hF, 1, 6'h23, 32'h2003, 2'd3);
    vecs[9]  = mk(4'h0, 6'h00, 32'h0,    4'hF, 0, 6'h23, 32'h2003, 2'd3);
    vecs[10] = mk(4'h4, 6'h03, 32'hDEADBEED, 4'hF, 0, 6'h23, 32'h2003, 2'd3);
    vecs[11] = mk(4'h0, 6'h00, 32'h0,    4'hF, 1, 6'h05, 32'hDEADBEEF, 2'd2);
    vecs[12] = mk(4'h0, 6'h00, 32'h0,    4'hF, 0, 6'h05, 32'hDEADBEEF, 2'd2);
    vecs[13] = mk(4'h9, 6'h30, 32'h3000, 4'hF, 0, 6'h05, 32'hDEADBEEF, 2'd2);
    vecs[14] = mk(4'h0, 6'h00, 32'h0,    4'hF, 1, 6'h33, 32'h3003, 2'd3);
    vecs[15] = mk(4'h0, 6'h00, 32'h0,    4'hF, 1, 6'h30, 32'h3000, 2'd0);
    vecs[16] = mk(4'h0, 6'h00, 32'h0,    4'hF, 0, 6'h30, 32'h3000, 2'd0);

    for (int r = 0; r < 17; r++) begin
      sub_valid = vecs[r].valid;
      sub_tag   = vecs[r].tag;
      sub_data  = vecs[r].data;
      flush     = vecs[r].flush;
      tick();
      chk($sformatf("vec%0d_ready", r), 32'(ready),     32'(vecs[r].exp_ready));
      chk($sformatf("vec%0d_valid", r), 32'(cdb_valid), 32'(vecs[r].exp_valid));
      chk($sformatf("vec%0d_tag", r),   32'(cdb_tag),   32'(vecs[r].exp_tag));
      chk($sformatf("vec%0d_data", r),  cdb_data,       vecs[r].exp_data);
      chk($sformatf("vec%0d_src", r),   32'(cdb_src),   32'(vecs[r].exp_src));
    end
    idle_inputs();

    // Unit 3 alone at one result per cycle: buffer wraps, ready never drops.
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      drive_one(3, 6'(40 + i), 32'hA000 + 32'(i));
      chk($sformatf("wrap%0d_ready3", i), 32'(ready[3]), 32'd1);
      tick();
      if (i == 0) begin
        chk("wrap0_valid", 32'(cdb_valid), 32'd0);
      end else begin
        chk($sformatf("wrap%0d_valid", i), 32'(cdb_valid), 32'd1);
        chk($sformatf("wrap%0d_tag", i),   32'(cdb_tag),   32'(40 + i - 1));
        chk($sformatf("wrap%0d_src", i),   32'(cdb_src),   32'd3);
      end
    end
    idle_inputs();
    tick();
    chk("wrap_last_valid", 32'(cdb_valid), 32'd1);
    chk("wrap_last_tag",   32'(cdb_tag),   32'd49);
    chk("wrap_last_data",  cdb_data,       32'hA009);
    tick();
    chk("wrap_end_valid",  32'(cdb_valid), 32'd0);

    // Backpressure: every unit submits whenever ready; scoreboard per unit.
    ready1_fell = 1'b0;
    for (int k = 0; k < 4; k++) seq[k] = 0;
    for (int c = 0; c < 48; c++) begin
      idle_inputs();
      if (c < 28) begin
        for (int k = 0; k < 4; k++) begin
          if (ready[k]) begin
            ft = {2'(k), 4'(seq[k])};
            drive_one(k, ft, 32'h5500_0000 | 32'(ft));
            exp_q[k].push_back(ft);
            seq[k]++;
          end
        end
        if (!ready[1]) ready1_fell = 1'b1;
      end
      tick();
      if (cdb_valid) begin
        if (exp_q[cdb_src].size() == 0) begin
          chk("bp_unexpected_bcast", 32'(cdb_tag), 32'hFFFF_FFFF);
        end else begin
          ft = exp_q[cdb_src].pop_front();
          chk("bp_tag",  32'(cdb_tag), 32'(ft));
          chk("bp_data", cdb_data,     32'h5500_0000 | 32'(ft));
        end
      end
    end
    chk("bp_ready1_fell", 32'(ready1_fell), 32'd1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("bp_leftover_u%0d", k), exp_q[k].size(), 32'd0);
    chk("bp_drained_valid", 32'(cdb_valid), 32'd0);

    // Flush with five entries buffered plus a unit 0 submit in the flush cycle.
    idle_inputs();
    for (int k = 0; k < 4; k++) drive_one(k, 6'(50 + k), 32'hF000 + 32'(k));
    tick();
    idle_inputs();
    drive_one(1, 6'd55, 32'hF005);
    drive_one(2, 6'd56, 32'hF006);
    tick();
    idle_inputs();
    flush = 1'b1;
    drive_one(0, 6'd58, 32'hF008);
    tick();
    chk("flush_valid", 32'(cdb_valid), 32'd0);
    chk("flush_ready", 32'(ready),     32'hF);
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("flush_quiet%0d", i), 32'(cdb_valid), 32'd0);
    end
    drive_one(1, 6'd60, 32'hCAFE);
    tick();
    idle_inputs();
    chk("postflush_lat1", 32'(cdb_valid), 32'd0);
    tick();
    chk("postflush_valid", 32'(cdb_valid), 32'd1);
    chk("postflush_tag",   32'(cdb_tag),   32'd60);
    chk("postflush_data",  cdb_data,       32'hCAFE);
    chk("postflush_src",   32'(cdb_src),   32'd1);
    tick();

    // Reset mid-stream while buffers hold entries.
    for (int k = 0; k < 4; k++) drive_one(k, 6'(1 + k), 32'h0B00 + 32'(k));
    tick();
    idle_inputs();
    tick();
    chk("pre_rst_valid", 32'(cdb_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(cdb_valid), 32'd0);
    chk("rst_mid_tag",   32'(cdb_tag),   32'd0);
    chk("rst_mid_data",  cdb_data,       32'd0);
    chk("rst_mid_ready", 32'(ready),     32'hF);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst_quiet%0d", i), 32'(cdb_valid), 32'd0);
    end

    // Single submit from unit 2 after reset.
    drive_one(2, 6'd5, 32'hDEADBEEF);
    tick();
    idle_inputs();
    chk("single_lat1_valid", 32'(cdb_valid), 32'd0);
    tick();
    chk("single_valid", 32'(cdb_valid), 32'd1);
    chk("single_tag",   32'(cdb_tag),   32'd5);
    chk("single_data",  cdb_data,       32'hDEADBEEF);
    chk("single_src",   32'(cdb_src),   32'd2);
    tick();
    chk("single_drop",  32'(cdb_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Receiving end of the execution-unit submit interface: collects results from the int, mult, div and mem execution units and broadcasts one result per cycle on the common data bus (CDB).
- Sits between the issue/execute stage and the CDB consumers: reservation stations, ROB and register status.
- Each unit gets a small per-unit buffer, so a unit's completion pulse is never lost while it waits for the bus.

Parameters:
- N_UNITS, 4, number of submitting units; index 0=int, 1=mult, 2=div, 3=mem.
- TAG_W, 6, width of the ROB/destination tag.
- DATA_W, 32, result width.
- DEPTH, 2, entries per unit buffer; power of 2, minimum 2.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous flush (branch mispredict); discards all buffered results
- i_submit_valid  in  N_UNITS  per-unit completion strobe (issue_done)
- i_submit_tag  in  N_UNITS*TAG_W  per-unit tag, unit k at bits [k*TAG_W +: TAG_W]
- i_submit_data  in  N_UNITS*DATA_W  per-unit result, same packing
- o_submit_ready  out  N_UNITS  per-unit buffer-not-full
- o_cdb_valid  out  1  broadcast valid
- o_cdb_tag  out  TAG_W  broadcast tag
- o_cdb_data  out  DATA_W  broadcast result
- o_cdb_src  out  $clog2(N_UNITS)  index of the unit being broadcast

Behaviour:
- Reset (async, i_rst_n low):
  - All buffers empty.
  - o_cdb_valid/tag/data/src = 0.
  - Round-robin pointer = 0, so unit 0 has highest priority.
  - o_submit_ready = all ones, since it is combinational !full.
- Submission:
  - Unit k's entry is written when i_submit_valid[k] && o_submit_ready[k].
  - o_submit_ready[k] depends only on the occupancy of buffer k, never on valid.
  - When buffer k is full, ready[k] is 0 even if buffer k is being popped that cycle (no push-while-full).
  - A valid while ready is 0 is a unit protocol error; it is dropped, and a simulation-only assertion fires.
- Arbitration (every cycle):
  - Candidates are the units whose buffer is non-empty.
  - Round-robin: search starts at pointer, wraps modulo N_UNITS.
  - Winner's head entry is popped.
  - Pointer becomes winner+1 (wrapping from N_UNITS-1 to 0). Pointer is unchanged when there is no winner.
- Broadcast:
  - CDB outputs are registered, loaded from the winner on the same edge as the pop.
  - o_cdb_valid is high for exactly one cycle per result.
  - When there is no winner, o_cdb_valid = 0 and tag/data/src hold their previous values.
- Latency without bypass: push at edge t, earliest o_cdb_valid after edge t+1 (2 cycles).
- Throughput: 1 result/cycle aggregate. A single unit submitting every cycle with the others idle sustains 1/cycle without ready deasserting.
- Simultaneous push and pop on the same buffer (not full): both take effect, occupancy unchanged.
- Flush:
  - On the next edge all buffers are emptied and o_cdb_valid = 0.
  - A submission arriving in the flush cycle is discarded.
  - Pointer is retained.
- Buffer pointers wrap modulo DEPTH. Occupancy is a counter 0..DEPTH.

Optional Feature:
- Macro CDB_BYPASS_EN.
- Defined: a unit whose buffer is empty may compete with its incoming i_submit_valid in the same cycle.
  - If it wins, its data goes straight into the CDB registers and is not written to the buffer, giving 1-cycle latency.
  - If it loses, it is buffered normally.
- Undefined: only buffered entries compete; latency is 2 cycles.
- Round-robin ordering and flush semantics are identical in both builds.

Decomposition:
- Shared package (utils.sv): unit index constants (UNIT_INT=0, UNIT_MULT=1, UNIT_DIV=2, UNIT_MEM=3) and a cdb_bcast_t struct {valid, tag, data, src} for downstream consumers.
- One sub-module: cdb_slot_fifo. Parameterized DEPTH/TAG_W/DATA_W, with push, pop, flush, full, empty, head outputs. Instantiated N_UNITS times.
- Round-robin select stays inline in cdb_arbiter.

Test Plan:
- Reset mid-stream: buffers hold entries, i_rst_n pulses low -> o_cdb_valid=0 immediately; ready=4'b1111; no stale broadcast after release.
- Single submit: unit 2, tag=5, data=0xDEADBEEF at cycle 10 -> o_cdb_valid=1, tag=5, src=2 at cycle 12 (cycle 11 with CDB_BYPASS_EN); valid low at cycle 13.
- All four units submit in one cycle, pointer=0 -> broadcasts in src order 0,1,2,3 on consecutive cycles. Repeat immediately -> order 0,1,2,3 again (pointer back at 0).
- Backpressure: other units' buffers kept non-empty so unit 1 wins only every 4th cycle; unit 1 submits every cycle -> ready[1] falls after its buffer reaches DEPTH=2; no tag lost or duplicated; each unit's tags broadcast in submission order.
- Flush with 5 entries buffered plus a unit 0 submit in the same cycle -> o_cdb_valid=0 next cycle and no later broadcast of any of the 6 tags; next submit broadcasts normally.
- Wrap: unit 3 pushes 10 tags at 1/cycle, others idle -> 10 consecutive broadcasts, tags in order, ready[3] never 0.
